hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Companion to the EX-stage forwarding logic in the 5-stage RISC-V pipeline.
- Forwarding supplies operands when a value already exists. This block handles the hazards forwarding cannot resolve:
  - load-use dependencies, handled by stalling and inserting a bubble;
  - taken branches resolved in EX, handled by flushing;
  - multi-cycle data-memory accesses, handled by freezing the pipeline.
- Keeps saturating stall/flush performance counters and a sticky dmem timeout error.

Parameters:
- DMEM_TIMEOUT, 255: maximum consecutive dmem wait cycles before entering ERR; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.
- WAIT_W, 8: width of the internal wait counter; must satisfy DMEM_TIMEOUT < 2^WAIT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_ex_rd  in  5  rd of the instruction in EX.
- id_ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  taken branch/jump resolved in EX this cycle.
- ex_mem_mem_req  in  1  MEM-stage instruction accesses dmem.
- dmem_ready  in  1  dmem completes the access this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX register enable.
- ex_mem_write  out  1  EX/MEM register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load bubble (control zeroed) into ID/EX.
- mem_wb_bubble  out  1  load bubble into MEM/WB.
- stall_cnt  out  CNT_W  count of stall cycles.
- flush_cnt  out  CNT_W  count of branch-flush cycles.
- dmem_timeout_err  out  1  sticky timeout flag.

Behaviour:
- States: RUN, MEM_WAIT, ERR. On rst_n=0 (asynchronous): state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, dmem_timeout_err=0.
- Control outputs are combinational from state and inputs (zero-latency, same cycle). Default values: all *_write=1, all flush/bubble=0.
- freeze = (ex_mem_mem_req & ~dmem_ready) | (state==ERR).
  - Effect: pc_write, if_id_write, id_ex_write and ex_mem_write are all 0; mem_wb_bubble=1; both flushes=0.
- load_use = id_ex_mem_read & id_ex_rd!=0 & ((id_uses_rs1 & id_ex_rd==id_rs1) | (id_uses_rs2 & id_ex_rd==id_rs2)).
- Priority: freeze > branch > load_use.
  - Branch (ex_branch_taken & ~freeze): if_id_flush=1, id_ex_flush=1, pc_write=1. The load_use stall is suppressed because the dependent instruction is being squashed.
  - Load_use (~freeze & ~ex_branch_taken): pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble per occurrence; afterwards forwarding supplies the value from MEM/WB.
- Register index 0 never causes a stall.
- State transitions:
  - RUN -> MEM_WAIT when ex_mem_mem_req & ~dmem_ready; wait_cnt<=1.
  - MEM_WAIT, ~dmem_ready: stay; wait_cnt+=1.
  - MEM_WAIT, dmem_ready: the release cycle.
    - freeze=0 and normal branch/load_use evaluation applies.
    - Next state RUN; wait_cnt<=0.
  - MEM_WAIT -> ERR when DMEM_TIMEOUT!=0, wait_cnt==DMEM_TIMEOUT and ~dmem_ready. dmem_timeout_err<=1.
  - ERR: held until reset; freeze=1 permanently.
- A dmem_ready arriving in the same cycle as the timeout compare wins: the next state is RUN, not ERR.
- Back-to-back dmem accesses: a release cycle followed by a new not-ready access re-enters MEM_WAIT with wait_cnt=1.
- In RUN with ex_mem_mem_req & dmem_ready, no freeze occurs and the state is unchanged.
- stall_cnt increments on every cycle with freeze | load_use, including ERR cycles; it saturates at all-ones.
- flush_cnt increments on every branch-flush cycle; it saturates at all-ones.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN immediately, with counters and the error flag cleared.

Test Plan:
- Load-use: load x5 in EX, ID add reads x5 via rs2 → exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0→1.
- Load with rd=x0, and a load x5 where the ID instruction does not use that operand → no stall; all writes=1.
- Branch and load-use in the same cycle → if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt +1; stall_cnt unchanged.
- dmem wait:
  - Stimulus: ex_mem_mem_req=1, dmem_ready low for 3 cycles then high.
  - Response: 3 freeze cycles with mem_wb_bubble=1 and all writes 0; release on cycle 4; stall_cnt=3; state back to RUN.
- Timeout:
  - Stimulus: DMEM_TIMEOUT=4, dmem_ready held low.
  - Response: ERR entered after 4 wait cycles; dmem_timeout_err=1 and stays frozen despite dmem_ready=1; rst_n low clears all.
- Saturation: CNT_W=4 with 20 consecutive stall cycles → stall_cnt holds 15.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Hazard and stall control for a 5-stage RISC-V pipeline. It handles load-use
// stalls, EX-resolved branch flushes and dmem wait freezes, and it keeps perf counters.
module hazard_stall_unit #(
  parameter int unsigned DMEM_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned WAIT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             dmem_timeout_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(DMEM_TIMEOUT);
  localparam bit                TIMEOUT_EN  = (DMEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;

  logic rs1_match;
  logic rs2_match;
  logic load_use;
  logic dmem_stall;
  logic freeze;
  logic branch_flush;
  logic load_stall;

  // x0 is hardwired to zero, so a load targeting it can never feed a consumer.
  assign rs1_match  = id_uses_rs1 && (id_ex_rd == id_rs1);
  assign rs2_match  = id_uses_rs2 && (id_ex_rd == id_rs2);
  assign load_use   = id_ex_mem_read && (id_ex_rd != 5'd0) && (rs1_match || rs2_match);

  assign dmem_stall   = ex_mem_mem_req && !dmem_ready;
  assign freeze       = dmem_stall || (state_q == ERR);
  assign branch_flush = ex_branch_taken && !freeze;
  assign load_stall   = load_use && !ex_branch_taken && !freeze;

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_flush) begin
      // The squashed ID instruction makes any pending load-use stall moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      RUN: begin
        if (dmem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end
      end
      MEM_WAIT: begin
        // A ready arriving on the timeout compare cycle still releases normally.
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT_VAL)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign dmem_timeout_err = err_q;

  // Counter 0 counts stall cycles and counter 1 counts branch-flush cycles. Both saturate.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign cnt_inc[0] = freeze || load_stall;
  assign cnt_inc[1] = branch_flush;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (cnt_inc[gi] && (cnt_q[gi] != CNT_MAX)) begin
          cnt_d[gi] = cnt_q[gi] + CNT_ONE;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign stall_cnt = cnt_q[0];
  assign flush_cnt = cnt_q[1];

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit that uses a combinational vector table
// and hand-written multi-cycle sequences for dmem waits, timeouts and saturation.
module tb_hazard_stall_unit;

  localparam int CW = 4;
  localparam logic [6:0] NORM   = 7'b1111000;
  localparam logic [6:0] LSTALL = 7'b0011010;
  localparam logic [6:0] BRF    = 7'b1111110;
  localparam logic [6:0] FRZ    = 7'b0000001;

  logic          clk;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, id_ex_rd;
  logic          id_uses_rs1, id_uses_rs2, id_ex_mem_read;
  logic          ex_branch_taken, ex_mem_mem_req, dmem_ready;
  logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic          if_id_flush, id_ex_flush, mem_wb_bubble;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          dmem_timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall;
  int exp_flush;

  hazard_stall_unit #(
    .DMEM_TIMEOUT(4),
    .CNT_W       (CW),
    .WAIT_W      (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_ex_rd        (id_ex_rd),
    .id_ex_mem_read  (id_ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ex_mem_mem_req  (ex_mem_mem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .dmem_timeout_err(dmem_timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp_ctl;
    int         ds;
    int         df;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [6:0] ctl();
    return {pc_write, if_id_write, id_ex_write, ex_mem_write,
            if_id_flush, id_ex_flush, mem_wb_bubble};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic ld,
                       input logic br, input logic req, input logic rdy);
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_uses_rs1     = u1;
    id_uses_rs2     = u2;
    id_ex_rd        = rd;
    id_ex_mem_read  = ld;
    ex_branch_taken = br;
    ex_mem_mem_req  = req;
    dmem_ready      = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the combinational controls for the driven inputs and then advance one clock.
  task automatic cyc(input string nm, input logic [6:0] exp_ctl);
    #1;
    chk(nm, ctl(), exp_ctl);
    $display("cycle %s ctl=%b stall=%0d flush=%0d err=%0b", nm, ctl(), stall_cnt,
             flush_cnt, dmem_timeout_err);
    tick();
  endtask

  task automatic chk_cnt(input string nm, input int s, input int f, input logic e);
    chk({nm, "_stall_cnt"}, 32'(stall_cnt), s);
    chk({nm, "_flush_cnt"}, 32'(flush_cnt), f);
    chk({nm, "_err"}, 32'(dmem_timeout_err), 32'(e));
  endtask

  task automatic sync_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // In vector order, the fields are rs1, rs2, u1, u2, rd, ld, br, req, rdy, ctl, dstall and dflush.
    vecs[0] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NORM,   0, 0};
    vecs[1] = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LSTALL, 1, 0};
    vecs[2] = '{5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LSTALL, 1, 0};
    vecs[3] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM,   0, 0};
    vecs[4] = '{5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NORM,   0, 0};
    vecs[5] = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NORM,   0, 0};
    vecs[6] = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, BRF,    0, 1};
    vecs[7] = '{5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, BRF,    0, 1};
    vecs[8] = '{5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, NORM,   0, 0};
    vecs[9] = '{5'd8, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, LSTALL, 1, 0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_ctl", ctl(), NORM);
    chk_cnt("reset", 0, 0, 1'b0);
    rst_n = 1'b1;
    tick();

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
            vecs[i].ld, vecs[i].br, vecs[i].req, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_ctl", i), ctl(), vecs[i].exp_ctl);
      tick();
      exp_stall += vecs[i].ds;
      exp_flush += vecs[i].df;
      chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), exp_stall);
      chk($sformatf("vec%0d_flush", i), 32'(flush_cnt), exp_flush);
      $display("vec %0d ctl=%b stall=%0d flush=%0d", i, ctl(), stall_cnt, flush_cnt);
    end

    // This sequence tests a three-cycle dmem wait. The branch and load-use in the middle cycle are masked by the freeze.
    sync_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("wait1", FRZ);
    drive(1, 5, 1, 1, 5, 1, 1, 1, 0);
    cyc("wait2", FRZ);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("wait3", FRZ);
    chk_cnt("wait3", 3, 0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("release", NORM);
    chk_cnt("release", 3, 0, 1'b0);

    // This sequence tests a release followed immediately by a new access that is not ready.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("b2b_wait", FRZ);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("b2b_rel", NORM);
    chk_cnt("b2b", 4, 0, 1'b0);

    // This sequence tests a dmem ready that arrives on the same cycle as the timeout compare. The ready must win.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc("edge_wait", FRZ);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("edge_rel", NORM);
    chk_cnt("edge", 8, 0, 1'b0);
    drive(1, 5, 1, 1, 5, 1, 0, 0, 0);
    cyc("edge_lu", LSTALL);
    chk_cnt("edge_lu", 9, 0, 1'b0);

    // This sequence asserts the asynchronous reset in the middle of MEM_WAIT.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mw_a", FRZ);
    cyc("mw_b", FRZ);
    chk_cnt("mw", 11, 0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mw_rst_ctl", ctl(), NORM);
    chk_cnt("mw_rst", 0, 0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();

    // This sequence tests the timeout. It enters ERR after the compare cycle and then stays frozen.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc("to_wait", FRZ);
    chk_cnt("to_pre", 4, 0, 1'b0);
    cyc("to_cmp", FRZ);
    chk_cnt("to_err", 5, 0, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("err_rdy", FRZ);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("err_idle", FRZ);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("err_br", FRZ);
    chk_cnt("err_hold", 8, 0, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("err_sat", FRZ);
    chk_cnt("err_sat", 15, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("err_rst_ctl", ctl(), NORM);
    chk_cnt("err_rst", 0, 0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("post_rst", NORM);

    // This sequence tests counter saturation for 20 load-use cycles and 17 branch cycles.
    drive(1, 5, 1, 1, 5, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("lu_sat", LSTALL);
    chk_cnt("lu_sat", 15, 0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 17; i++) cyc("br_sat", BRF);
    chk_cnt("br_sat", 15, 15, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
